// File: rtl/nios2_qsys_mult_seq_if.sv
// Request/result handshake bundle for the iterative multiplier.
// The master drives requests and result acceptance; the slave is the multiplier.
interface nios2_qsys_mult_seq_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        output in_valid, in_op, in_src1, in_src2, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/nios2_qsys_mult_seq.sv
// Iterative DATA_W x DATA_W multiplier, one SLICE_W slice of src2 per cycle,
// returning the low half or the unsigned/mixed/signed high half.
//
// state | meaning
// IDLE  | ready for a request; operands captured on in_valid
// CALC  | accumulate one partial product per cycle, N cycles
// FIX   | select half and apply signed corrections, register result
// DONE  | hold result until res_ready
module nios2_qsys_mult_seq #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    nios2_qsys_mult_seq_if.slave    bus
);
    localparam int N  = DATA_W / SLICE_W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_op;
    logic [DATA_W-1:0]     r_src1;
    logic [DATA_W-1:0]     r_src2;
    logic [2*DATA_W-1:0]   r_acc;
    logic [KW-1:0]         r_k;
    logic [DATA_W-1:0]     r_res_data;
    logic                  r_res_valid;

    logic [SLICE_W-1:0]    w_slice;
    logic [2*DATA_W-1:0]   w_pp;
    logic [DATA_W-1:0]     w_hi;
    logic [DATA_W-1:0]     w_corr1;
    logic [DATA_W-1:0]     w_corr2;
    logic [DATA_W-1:0]     w_fix_res;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_nxt = CALC;
            CALC:    if (r_k == K_LAST) w_state_nxt = FIX;
            FIX:                        w_state_nxt = DONE;
            DONE:    if (bus.res_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // Partial product is the unsigned slice product placed at its slice position.
    always_comb begin
        w_slice = SLICE_W'(r_src2 >> (int'(r_k) * SLICE_W));
        w_pp    = ({{DATA_W{1'b0}}, r_src1} *
                   {{(2*DATA_W-SLICE_W){1'b0}}, w_slice}) << (int'(r_k) * SLICE_W);
    end

    // Signed high halves fall out of the unsigned high half by subtracting the
    // other operand once for each negative operand, modulo 2^DATA_W.
    always_comb begin
        w_hi      = r_acc[2*DATA_W-1:DATA_W];
        w_corr1   = (r_op[1] && r_src1[DATA_W-1]) ? r_src2 : '0;
        w_corr2   = (r_op == 2'd3 && r_src2[DATA_W-1]) ? r_src1 : '0;
        w_fix_res = '0;
        case (r_op)
            2'd0:    w_fix_res = r_acc[DATA_W-1:0];
            2'd1:    w_fix_res = w_hi;
            2'd2:    w_fix_res = w_hi - w_corr1;
            default: w_fix_res = w_hi - w_corr1 - w_corr2;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_op   <= bus.in_op;
                        r_src1 <= bus.in_src1;
                        r_src2 <= bus.in_src2;
                        r_acc  <= '0;
                        r_k    <= '0;
                    end
                end
                CALC: begin
                    r_acc <= r_acc + w_pp;
                    r_k   <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                end
                FIX: begin
                    r_res_data  <= w_fix_res;
                    r_res_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.res_ready) r_res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
endmodule
